accum_stage3_relu: RTL and testbench
====================================

Name: accum_stage3_relu

Overview:
- Convolution stage 3. Consumes the 18-bit signed partial sums produced by the stage-2 three-input adders.
- Accumulates NUM_TERMS consecutive partial sums, one per kernel row or channel, into a single output pixel, and adds a per-filter bias.
- Rescales the fixed-point result by an arithmetic right shift, optionally applies ReLU, and saturates to 16-bit signed.
- Emits the result with a one-cycle valid pulse for the next layer or the pooling stage.

Parameters:
- IN_W, 18: width of the signed input partial sum (matches the stage-2 output).
- ACC_W, 24: signed accumulator width. Must satisfy ACC_W >= IN_W + clog2(NUM_TERMS+1) + 1.
- OUT_W, 16: width of the signed saturated output.
- NUM_TERMS, 3: partial sums per output pixel. Legal range 1..255.
- SHIFT, 2: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: block enable. Low means soft clear (see Behaviour).
- in_valid, input, 1: input1 carries a valid partial sum this cycle.
- input1, input, IN_W: signed partial sum from stage 2.
- bias, input, OUT_W: signed per-filter bias, sampled on the first term of each group.
- relu_en, input, 1: 1 means negative results are clamped to 0. Sampled at emit.
- output1, output, OUT_W: signed result. Holds its value between pulses.
- out_valid, output, 1: one-cycle pulse marking a new output1.
- busy, output, 1: high while a group is partially accumulated (cnt != 0).

Behaviour:

Reset (reset=1 at an edge):
- cnt, acc, output1, out_valid and the emit flag all go to 0.
- Reset has priority over everything else, including a mid-group state and a pending emit.

enable=0 at an edge (reset=0):
- Same clearing effect as reset: a partial group and any pending emit are discarded.
- in_valid is ignored.

States, implicit in cnt (0..NUM_TERMS-1):
- IDLE: cnt=0.
- ACCUM: cnt>0.
- A separate emit flag forms a 1-deep output pipeline register.

Accept rule (enable=1, in_valid=1):
- If cnt==0: acc <= sext(bias) + sext(input1).
- Else: acc <= acc + sext(input1).
- cnt increments. On the term where cnt==NUM_TERMS-1, cnt wraps to 0 and emit is set for the next cycle.
- With NUM_TERMS=1, every accepted term both starts and ends a group.

Gaps:
- in_valid=0 holds cnt and acc unchanged. There is no timeout.

Emit (the cycle after the last term is accepted):
- r = acc >>> SHIFT (arithmetic shift, floor rounding).
- If relu_en and r<0, r=0.
- Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- output1 <= saturated r; out_valid <= 1 for exactly one cycle.

Latency and throughput:
- out_valid rises on the edge after the edge that accepted the final term.
- The next group may start on that same emit edge. Back-to-back groups run with no bubbles (throughput 1 term/cycle).
- acc for the new group must not corrupt the value being emitted. The emitted value is captured from the old acc.

Other rules:
- out_valid=0 whenever no emit is pending. output1 is never zeroed except by reset or enable=0.
- busy = (cnt != 0).
- Overflow of acc cannot occur within the legal parameter range. No wrap is permitted.

Test Plan:
1. Basic sum (NUM_TERMS=3, SHIFT=2, relu_en=1): bias=4, inputs 100, 200, 300 on consecutive cycles -> acc=604; output1=151 with out_valid high for 1 cycle, one edge after the third accept. busy=1 after terms 1 and 2, 0 after term 3.
2. Negative and ReLU: bias=0, inputs -100, -200, -300 -> output1=0 with relu_en=1; repeat with relu_en=0 -> output1=-150.
3. Saturation: bias=32767, inputs 131071 x3 -> acc=425980, shifted 106495, output1=32767. Then bias=-32768, inputs -131072 x3, relu_en=0 -> output1=-32768.
4. Gaps and back-to-back:
   - in_valid on cycles 0, 3, 7 with test-1 values -> output1=151, out_valid at cycle 8.
   - Six consecutive valid terms (100,200,300,1,2,3; bias=4) -> pulses 3 cycles apart with output1=151, then output1=2 ((4+6)>>>2).
5. Reset and enable mid-group:
   - After 2 accepted terms assert reset for 1 cycle -> busy=0, output1=0, no out_valid. The next 3 terms (bias=4; 100, 200, 300) give output1=151.
   - Repeat using enable=0 for 1 cycle -> same result.
   - enable=0 on the emit edge -> no out_valid pulse.

Source files
------------

// File: rtl/accum_stage3_relu.sv
// rtl/accum_stage3_relu.sv - stage-3 conv accumulator: group sum + bias, rescale, optional ReLU, saturate
// Accepts NUM_TERMS signed partial sums per pixel and emits one saturated result per group.
module accum_stage3_relu #(
    parameter int IN_W      = 18,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int NUM_TERMS = 3,
    parameter int SHIFT     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  input1,
    input  logic signed [OUT_W-1:0] bias,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] output1,
    output logic                    out_valid,
    output logic                    busy
);

    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    emit_q, emit_d;
    logic signed [OUT_W-1:0] output1_q, output1_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] rectified;
    logic signed [OUT_W-1:0] saturated;

    always_comb begin
        bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
        in_ext   = {{(ACC_W-IN_W){input1[IN_W-1]}}, input1};
        // The first term of a group seeds the accumulator with the bias.
        acc_base = (cnt_q == '0) ? bias_ext : acc_q;
        acc_sum  = acc_base + in_ext;
    end

    // Result path reads acc_q only, so a group starting on the emit edge
    // cannot disturb the value being emitted.
    always_comb begin
        shifted   = acc_q >>> SHIFT;
        rectified = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
        if (rectified > OUT_MAX) begin
            saturated = OUT_MAX[OUT_W-1:0];
        end else if (rectified < OUT_MIN) begin
            saturated = OUT_MIN[OUT_W-1:0];
        end else begin
            saturated = rectified[OUT_W-1:0];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        emit_d      = 1'b0;
        out_valid_d = emit_q;
        output1_d   = emit_q ? saturated : output1_q;

        if (in_valid) begin
            acc_d = acc_sum;
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                emit_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Soft clear: drops a partial group and any pending emit.
        if (!enable) begin
            cnt_d       = '0;
            acc_d       = '0;
            emit_d      = 1'b0;
            out_valid_d = 1'b0;
            output1_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            emit_q      <= 1'b0;
            output1_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            emit_q      <= emit_d;
            output1_q   <= output1_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign output1   = output1_q;
    assign out_valid = out_valid_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_accum_stage3_relu.sv
// tb/tb_accum_stage3_relu.sv - self-checking bench for accum_stage3_relu
module tb_accum_stage3_relu;

    localparam int N_TERMS = 3;
    localparam int SHIFT   = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [17:0] input1 = '0;
    logic signed [15:0] bias = '0;
    logic               relu_en = 1'b0;
    logic signed [15:0] output1;
    logic               out_valid;
    logic               busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int     terms[$];
    int     grp_bias = 0;
    bit     pend = 1'b0;
    longint pend_sum = 0;
    bit     exp_valid = 1'b0;
    int     exp_out = 0;
    bit     exp_busy = 1'b0;

    accum_stage3_relu dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .input1   (input1),
        .bias     (bias),
        .relu_en  (relu_en),
        .output1  (output1),
        .out_valid(out_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int finish_val(input longint s, input bit relu);
        longint d;
        longint q;
        d = longint'(1) << SHIFT;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // Drives one clock of stimulus and advances the reference model.
    task automatic drive(input bit rst, input bit en, input bit iv,
                         input int x, input int b, input bit relu);
        longint s;
        reset    = rst;
        enable   = en;
        in_valid = iv;
        input1   = x[17:0];
        bias     = b[15:0];
        relu_en  = relu;
        if (rst || !en) begin
            terms.delete();
            pend      = 1'b0;
            exp_valid = 1'b0;
            exp_out   = 0;
        end else begin
            exp_valid = pend;
            if (pend) exp_out = finish_val(pend_sum, relu);
            pend = 1'b0;
            if (iv) begin
                if (terms.size() == 0) grp_bias = b;
                terms.push_back(x);
                if (terms.size() == N_TERMS) begin
                    s = grp_bias;
                    foreach (terms[i]) s += terms[i];
                    pend     = 1'b1;
                    pend_sum = s;
                    terms.delete();
                end
            end
        end
        exp_busy = (terms.size() != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1000, 5, 1);
        drive(1, 1, 1, 1000, 5, 1);
        tests_run++;
        if (output1 !== 16'sd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: output1=%0d out_valid=%b busy=%b required 0/0/0",
                     output1, out_valid, busy);
        end
        drive(0, 1, 0, 0, 0, 1);
    endtask

    task automatic test_basic();
        drive(0, 1, 1, 100, 4, 1);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy_t1: busy=%b required 1", busy);
        end
        drive(0, 1, 1, 200, 4, 1);
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_t2: busy=%b out_valid=%b required 1/0", busy, out_valid);
        end
        drive(0, 1, 1, 300, 4, 1);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_t3: busy=%b out_valid=%b required 0/0", busy, out_valid);
        end
        drive(0, 1, 0, 0, 0, 1);
        tests_run++;
        if (out_valid !== 1'b1 || output1 !== 16'sd151) begin
            tests_failed++;
            $display("FAIL basic_emit: out_valid=%b output1=%0d required 1/151", out_valid, output1);
        end
        drive(0, 1, 0, 0, 0, 1);
        tests_run++;
        if (out_valid !== 1'b0 || output1 !== 16'sd151) begin
            tests_failed++;
            $display("FAIL basic_hold: out_valid=%b output1=%0d required 0/151", out_valid, output1);
        end
    endtask

    task automatic test_relu();
        for (int pass = 0; pass < 2; pass++) begin
            bit r;
            int want;
            r    = (pass == 0);
            want = r ? 0 : -150;
            drive(0, 1, 1, -100, 0, r);
            drive(0, 1, 1, -200, 0, r);
            drive(0, 1, 1, -300, 0, r);
            drive(0, 1, 0, 0, 0, r);
            tests_run++;
            if (out_valid !== 1'b1 || output1 !== 16'(want)) begin
                tests_failed++;
                $display("FAIL relu_%0d: out_valid=%b output1=%0d required 1/%0d",
                         r, out_valid, output1, want);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 131071, 32767, 1);
        drive(0, 1, 0, 0, 0, 1);
        tests_run++;
        if (out_valid !== 1'b1 || output1 !== 16'sd32767) begin
            tests_failed++;
            $display("FAIL sat_pos: out_valid=%b output1=%0d required 1/32767", out_valid, output1);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, 1, -131072, -32768, 0);
        drive(0, 1, 0, 0, 0, 0);
        tests_run++;
        if (out_valid !== 1'b1 || output1 !== -16'sd32768) begin
            tests_failed++;
            $display("FAIL sat_neg: out_valid=%b output1=%0d required 1/-32768", out_valid, output1);
        end
    endtask

    task automatic test_gaps();
        int vals[3] = '{100, 200, 300};
        int k = 0;
        int pulse_at = -1;
        drive(0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 3 || c == 7) begin
                drive(0, 1, 1, vals[k], 4, 1);
                k++;
            end else begin
                drive(0, 1, 0, 0, 4, 1);
            end
            if (out_valid === 1'b1 && pulse_at < 0) pulse_at = c;
        end
        tests_run++;
        if (pulse_at != 8 || output1 !== 16'sd151) begin
            tests_failed++;
            $display("FAIL gaps: pulse_cycle=%0d output1=%0d required 8/151", pulse_at, output1);
        end
    endtask

    task automatic test_back_to_back();
        int vals[6] = '{100, 200, 300, 1, 2, 3};
        int pulses[$];
        int outs[$];
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive(0, 1, 1, vals[c], 4, 1);
            else       drive(0, 1, 0, 0, 4, 1);
            if (out_valid === 1'b1) begin
                pulses.push_back(c);
                outs.push_back(int'(output1));
            end
        end
        tests_run++;
        if (pulses.size() != 2 || pulses[0] != 3 || pulses[1] != 6 ||
            outs[0] != 151 || outs[1] != 2) begin
            tests_failed++;
            $display("FAIL back_to_back: pulses=%p outputs=%p required '{3,6} / '{151,2}",
                     pulses, outs);
        end
    endtask

    task automatic test_mid_group_clear();
        for (int mode = 0; mode < 2; mode++) begin
            bit seen;
            drive(0, 1, 1, 100, 4, 1);
            drive(0, 1, 1, 200, 4, 1);
            drive(mode == 0, mode == 1 ? 1'b0 : 1'b1, 1, 300, 4, 1);
            tests_run++;
            if (busy !== 1'b0 || output1 !== 16'sd0 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL clear_mode%0d: busy=%b output1=%0d out_valid=%b required 0/0/0",
                         mode, busy, output1, out_valid);
            end
            seen = 1'b0;
            drive(0, 1, 1, 100, 4, 1);
            seen |= (out_valid === 1'b1);
            drive(0, 1, 1, 200, 4, 1);
            seen |= (out_valid === 1'b1);
            drive(0, 1, 1, 300, 4, 1);
            seen |= (out_valid === 1'b1);
            drive(0, 1, 0, 0, 4, 1);
            tests_run++;
            if (seen || out_valid !== 1'b1 || output1 !== 16'sd151) begin
                tests_failed++;
                $display("FAIL clear_refill%0d: early=%b out_valid=%b output1=%0d required 0/1/151",
                         mode, seen, out_valid, output1);
            end
        end
    endtask

    task automatic test_enable_on_emit();
        drive(0, 1, 1, 100, 4, 1);
        drive(0, 1, 1, 200, 4, 1);
        drive(0, 1, 1, 300, 4, 1);
        drive(0, 0, 0, 0, 4, 1);
        tests_run++;
        if (out_valid !== 1'b0 || output1 !== 16'sd0) begin
            tests_failed++;
            $display("FAIL enable_on_emit: out_valid=%b output1=%0d required 0/0", out_valid, output1);
        end
        drive(0, 1, 0, 0, 4, 1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_on_emit_late: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 600; c++) begin
            logic signed [17:0] rx;
            logic signed [15:0] rb;
            bit rst, en, iv, rl;
            rx  = 18'($urandom);
            if ($urandom_range(0, 1) == 0) rx = 18'($signed($urandom_range(0, 2000)) - 1000);
            rb  = 16'($urandom);
            rst = ($urandom_range(0, 99) < 2);
            en  = ($urandom_range(0, 99) >= 4);
            iv  = ($urandom_range(0, 99) < 75);
            rl  = $urandom_range(0, 1);
            drive(rst, en, iv, int'(rx), int'(rb), rl);
            tests_run++;
            if (out_valid !== exp_valid || busy !== exp_busy || output1 !== 16'(exp_out)) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: out_valid=%b busy=%b output1=%0d required %b/%b/%0d",
                             c, out_valid, busy, output1, exp_valid, exp_busy, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_gaps();
        test_back_to_back();
        test_mid_group_clear();
        test_enable_on_emit();
        drive(1, 1, 0, 0, 0, 0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
